// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Issues sequential word fetches under a credit limit, tags each request with
// its PC, buffers in-order responses and presents {instr, pc} to decode.
// A redirect flushes everything; responses to older requests are counted and
// dropped as they return.
// Optional feature macro: MISALIGN_TRAP_EN. When defined, a misaligned redirect
// target halts fetch and delivers one fault entry (nop at redirect_pc) to
// decode; when undefined, redirect_pc[1:0] is ignored (forced to zero).
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc
`ifdef MISALIGN_TRAP_EN
   ,
   output logic        id_fault
`endif
);

   localparam int DEPTH = int'(FIFO_DEPTH);
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int CW    = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   // run holds off the first request until the first edge after reset release
   logic          run;
   logic [31:0]   pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] fifo_cnt;
   logic [PW-1:0] tag_rd;
   logic [PW-1:0] tag_wr;
   logic [PW-1:0] fifo_rd;
   logic [PW-1:0] fifo_wr;
   logic [31:0]   tag_mem   [DEPTH];
   logic [31:0]   instr_mem [DEPTH];
   logic [31:0]   pc_mem    [DEPTH];

   logic          halted;
   logic          push_fault;
   logic [31:0]   redirect_tgt;
   logic          credit_ok;
   logic          accept;
   logic          rsp_eff;
   logic          rsp_push;
   logic          fifo_push;
   logic          fifo_pop;
   logic [CW-1:0] outstanding_nxt;
   logic [31:0]   push_instr;
   logic [31:0]   push_pc;

`ifdef MISALIGN_TRAP_EN
   logic fault_pend;
   logic fault_mem [DEPTH];

   assign redirect_tgt = redirect_pc;
   // The fault entry waits until every pre-redirect response has been dropped;
   // fetch is halted, so no live response can compete for the push slot.
   assign push_fault   = fault_pend && (drop_cnt == '0) && !rsp_eff && !redirect_valid;
   assign id_fault     = fault_mem[fifo_rd];

   // Halt on a misaligned redirect target; only a later redirect clears it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         halted     <= 1'b0;
         fault_pend <= 1'b0;
      end else if (redirect_valid) begin
         halted     <= |redirect_pc[1:0];
         fault_pend <= |redirect_pc[1:0];
      end else if (push_fault) begin
         fault_pend <= 1'b0;
      end
   end
`else
   assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
   assign halted       = 1'b0;
   assign push_fault   = 1'b0;
`endif

   assign credit_ok       = ({1'b0, outstanding} + {1'b0, fifo_cnt}) < DEPTH_C;
   assign imem_req_valid  = run && !redirect_valid && credit_ok && !halted;
   assign imem_req_addr   = pc;
   assign accept          = imem_req_valid && imem_req_ready;
   // A response with nothing outstanding is a protocol error and is ignored
   assign rsp_eff         = imem_rsp_valid && (outstanding != '0);
   assign rsp_push        = rsp_eff && (drop_cnt == '0) && !redirect_valid;
   assign fifo_push       = rsp_push || push_fault;
   assign fifo_pop        = id_valid && id_ready && !redirect_valid;
   assign outstanding_nxt = outstanding + CW'(accept) - CW'(rsp_eff);
   assign push_instr      = push_fault ? 32'h0000_0013 : imem_rsp_data;
   assign push_pc         = push_fault ? pc : tag_mem[tag_rd];

   assign id_valid = (fifo_cnt != '0);
   assign id_instr = instr_mem[fifo_rd];
   assign id_pc    = pc_mem[fifo_rd];

   // PC, credit counters and queue pointers; redirect overrides everything
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run         <= 1'b0;
         pc          <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         tag_rd      <= '0;
         tag_wr      <= '0;
         fifo_rd     <= '0;
         fifo_wr     <= '0;
         fifo_cnt    <= '0;
      end else begin
         run         <= 1'b1;
         outstanding <= outstanding_nxt;
         if (redirect_valid) begin
            // Every request still outstanding after this cycle predates the
            // redirect, so all of them are to be dropped.
            pc       <= redirect_tgt;
            drop_cnt <= outstanding_nxt;
            tag_rd   <= '0;
            tag_wr   <= '0;
            fifo_rd  <= '0;
            fifo_wr  <= '0;
            fifo_cnt <= '0;
         end else begin
            if (accept) begin
               pc     <= pc + 32'd4;
               tag_wr <= tag_wr + 1'b1;
            end
            if (rsp_eff && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
            if (rsp_push)  tag_rd  <= tag_rd + 1'b1;
            if (fifo_push) fifo_wr <= fifo_wr + 1'b1;
            if (fifo_pop)  fifo_rd <= fifo_rd + 1'b1;
            fifo_cnt <= fifo_cnt + CW'(fifo_push) - CW'(fifo_pop);
         end
      end
   end

   // PC tag storage, written at request acceptance
   always_ff @(posedge clk) begin
      if (accept) tag_mem[tag_wr] <= pc;
   end

   // Decode-side entry storage; cleared on reset so id_instr/id_pc read zero
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem[i] <= '0;
            pc_mem[i]    <= '0;
`ifdef MISALIGN_TRAP_EN
            fault_mem[i] <= 1'b0;
`endif
         end
      end else if (fifo_push) begin
         instr_mem[fifo_wr] <= push_instr;
         pc_mem[fifo_wr]    <= push_pc;
`ifdef MISALIGN_TRAP_EN
         fault_mem[fifo_wr] <= push_fault;
`endif
      end
   end

endmodule
